seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIV_BITS, default 17, giving the prescaler width; one digit period is 2^DIV_BITS clk cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port data_in, input, 32 bits: the value to display, as eight hex nibbles.
REQ-005 The block SHALL have port data_valid, input, 1 bit: offers data_in for loading.
REQ-006 The block SHALL have port data_ready, output, 1 bit: high when the pending register is empty.
REQ-007 The block SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-008 The block SHALL have port dp_mask, input, 8 bits: decimal point per digit, 1 = lit.
REQ-009 The block SHALL have port SEG, output, 8 bits, active-low: SEG[0..6] = segments a..g, SEG[7] = dp.
REQ-010 The block SHALL have port AN, output, 8 bits, active-low: digit enables, one-hot.
REQ-011 The block SHALL have port frame_tick, output, 1 bit: a one-cycle pulse at each frame start.

Function
REQ-012 The prescaler SHALL be a free-running DIV_BITS counter; tick = counter all-ones.
REQ-013 States SHALL be: SHOW (AN low on the current digit) and GUARD (AN = 8'hFF for exactly one cycle).
- SHOW -> GUARD on tick.
- GUARD -> SHOW unconditionally; the digit index increments mod 8 on this transition.
REQ-014 On GUARD -> SHOW with index wrap 7 -> 0:
- frame_tick SHALL pulse for one cycle, concurrent with the first SHOW cycle of digit 0.
- If the pending register is full, it SHALL be copied to the display register and marked empty.
REQ-015 Load handshake: on data_valid && data_ready, data_in SHALL be written to the pending register and data_ready SHALL drop the next cycle; data_valid while data_ready is low SHALL be ignored.
REQ-016 If a transfer and a load coincide, the transfer SHALL move the old pending value; the load is impossible in that cycle because data_ready is low while pending is full.
REQ-017 Digit i SHALL show display[4i+3:4i] using the standard hex glyphs 0-9, A, b, C, d, E, F; dp is lit when dp_mask[i] = 1.
REQ-018 When blank_lz = 1, digit i (i >= 1) SHALL show all segments off, dp included, if nibbles i..7 are all zero; digit 0 is never blanked.
REQ-019 SEG and AN SHALL be registered outputs, changing one cycle after the state or index change that selects them.
REQ-020 Changes to blank_lz and dp_mask SHALL take effect at the next registered SEG update; they are not frame-synchronised.

Reset
REQ-021 While rst is low, and immediately on assertion:
- prescaler = 0, state = SHOW, index = 0;
- display register and pending register = 0, pending empty;
- data_ready = 1, frame_tick = 0;
- SEG = 8'hFF, AN = 8'hFF.
REQ-022 Reset asserted mid-frame or mid-handshake SHALL discard any pending value.
REQ-023 The first SHOW cycle after release SHALL drive digit 0 from the cleared display register, with no frame_tick pulse.

Structure
REQ-024 The following SHALL live in the shared CPU package and be reused by the display-select logic:
- the hex-to-segment glyph table;
- the state encoding;
- the SEG bit-order constants.
REQ-025 One sub-module, hex7seg (combinational nibble -> 7 segments, active-low), SHALL be instantiated once; the remainder is flat.

Verification
REQ-026 The bench SHALL run with DIV_BITS = 2 and cover these scenarios:
- Reset release: AN = 8'hFF and SEG = 8'hFF during reset; digit 0 shows "0" (SEG = 8'hC0) and digits 1-7 also show "0" with blank_lz = 0.
- Load 32'h1234ABCD mid-frame: data_ready drops for the rest of the frame; after the wrap, frame_tick pulses, digit 0 shows "d" (SEG = 8'hA1), digit 7 shows "1" (SEG = 8'hF9), and data_ready returns to 1.
- Back-to-back: data_valid held high with two values: the first is accepted, the second is refused until the frame transfer, then accepted and displayed in the following frame.
- blank_lz = 1 with value 32'h00000050: digits 2-7 are blank (SEG = 8'hFF), digit 1 = "5", digit 0 = "0"; value 0 shows only digit 0.
- Guard cycle: at every digit change, AN = 8'hFF for exactly one cycle, and AN is never multi-hot.
- Mid-frame reset with pending full: outputs return to the reset values immediately; after release, pending is empty and the display reads 0.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the eight-digit seven-segment scan driver.
// Contents:
//   scan_state_t  - scan FSM encoding (SHOW / GUARD)
//   SEG_*         - bit positions inside the active-low SEG bus
//   SEG_OFF/AN_OFF- all-dark patterns for the segment and anode buses
//   hex_glyph()   - hex nibble -> active-low segments a..g (bit 0 = a)
package seg_scan_driver_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_DIGITS = 8;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Glyphs for 0-9, A, b, C, d, E, F; a 0 bit lights the segment.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load handshake between a producer and the scan driver.
//   data_in    - 32-bit value, eight hex nibbles (nibble 0 = rightmost digit)
//   data_valid - producer offers data_in
//   data_ready - driver's pending register is empty
// Modports: master = producer, slave = seg_scan_driver.
interface seg_scan_driver_if;
  import seg_scan_driver_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/seg_scan_driver_hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment decoder.
//   nibble - 4-bit value 0..F
//   seg_n  - segments a..g in bits 0..6, 0 = lit
module hex7seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = hex_glyph(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an eight-digit, active-low
// seven-segment display with a one-cycle all-dark guard between digits and a
// frame-synchronised double-buffered load path.
// Ports:
//   clk        - clock, all state on the rising edge
//   rst        - asynchronous active-low reset
//   data_bus   - load handshake (data_in / data_valid / data_ready)
//   blank_lz   - suppress leading zeros (digit 0 always shown)
//   dp_mask    - decimal point per digit, 1 = lit
//   SEG        - active-low segments, [6:0] = a..g, [7] = dp (registered)
//   AN         - active-low one-hot digit enables (registered)
//   frame_tick - one-cycle pulse with the first SHOW cycle of digit 0
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DIV_BITS = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_scan_driver_if.slave     data_bus,
  input  logic                 blank_lz,
  input  logic [7:0]           dp_mask,
  output logic [7:0]           SEG,
  output logic [7:0]           AN,
  output logic                 frame_tick
);

  localparam logic [DIV_BITS-1:0] PRESC_ONE = {{(DIV_BITS-1){1'b0}}, 1'b1};

  logic [DIV_BITS-1:0] presc_reg;
  scan_state_t         state_reg;
  logic [2:0]          idx_reg;
  logic [DATA_W-1:0]   display_reg;
  logic [DATA_W-1:0]   pending_reg;
  logic                pending_full_reg;
  logic [7:0]          seg_reg;
  logic [7:0]          an_reg;
  logic                frame_tick_reg;

  logic                tick;
  logic                frame_wrap;

  // Per-digit nibble and "this nibble and everything above it is zero".
  logic [3:0]          nib_arr [NUM_DIGITS];
  logic [7:0]          upper_zero;

  logic [3:0]          cur_nib;
  logic [6:0]          glyph_n;
  logic                blank_cur;
  logic [7:0]          seg_next;

  assign tick       = &presc_reg;
  assign frame_wrap = (state_reg == ST_GUARD) && (idx_reg == 3'd7);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib_arr[gi]    = display_reg[4*gi +: 4];
      assign upper_zero[gi] = ~|display_reg[DATA_W-1:4*gi];
    end
  endgenerate

  assign cur_nib = nib_arr[idx_reg];

  hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg_n  (glyph_n)
  );

  assign blank_cur = blank_lz && (idx_reg != 3'd0) && upper_zero[idx_reg];

  // Segment pattern for the digit currently selected; dark during GUARD so
  // nothing ghosts onto the neighbouring digit.
  always_comb begin
    seg_next = SEG_OFF;
    if ((state_reg == ST_SHOW) && !blank_cur) begin
      seg_next[SEG_G:SEG_A] = glyph_n;
      seg_next[SEG_DP]      = ~dp_mask[idx_reg];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg        <= '0;
      state_reg        <= ST_SHOW;
      idx_reg          <= 3'd0;
      display_reg      <= '0;
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      seg_reg          <= SEG_OFF;
      an_reg           <= AN_OFF;
      frame_tick_reg   <= 1'b0;
    end else begin
      presc_reg <= presc_reg + PRESC_ONE;

      case (state_reg)
        ST_SHOW: begin
          if (tick) begin
            state_reg <= ST_GUARD;
          end
        end
        default: begin
          state_reg <= ST_SHOW;
          idx_reg   <= idx_reg + 3'd1;
        end
      endcase

      // Registered so the pulse lines up with the first SHOW cycle of digit 0.
      frame_tick_reg <= frame_wrap;

      // Transfer and load are mutually exclusive: a load needs the pending
      // register empty, a transfer needs it full.
      if (frame_wrap && pending_full_reg) begin
        display_reg      <= pending_reg;
        pending_full_reg <= 1'b0;
      end else if (data_bus.data_valid && !pending_full_reg) begin
        pending_reg      <= data_bus.data_in;
        pending_full_reg <= 1'b1;
      end

      an_reg  <= (state_reg == ST_GUARD) ? AN_OFF : ~(8'b0000_0001 << idx_reg);
      seg_reg <= seg_next;
    end
  end

  assign data_bus.data_ready = ~pending_full_reg;
  assign SEG                 = seg_reg;
  assign AN                  = an_reg;
  assign frame_tick          = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       blank_lz = 1'b0;
  logic [7:0] dp_mask = 8'h00;
  logic [7:0] SEG;
  logic [7:0] AN;
  logic       frame_tick;

  seg_scan_driver_if bus ();

  always #5 clk = ~clk;

  seg_scan_driver #(.DIV_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_bus   (bus),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .SEG        (SEG),
    .AN         (AN),
    .frame_tick (frame_tick)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Timeline with a 4-cycle digit period: counting rising edges since reset
  // release from 1, the scan position after edge j is GUARD when j is a
  // nonzero multiple of 4, otherwise digit (j/4) mod 8.  Outputs after edge
  // j+1 show the position after edge j.  A frame starts at edges 33, 65, ...

  function automatic logic [6:0] glyph_on(input logic [3:0] n);
    logic [6:0] t;
    case (n)
      4'h0: t = 7'h3F; 4'h1: t = 7'h06; 4'h2: t = 7'h5B; 4'h3: t = 7'h4F;
      4'h4: t = 7'h66; 4'h5: t = 7'h6D; 4'h6: t = 7'h7D; 4'h7: t = 7'h07;
      4'h8: t = 7'h7F; 4'h9: t = 7'h6F; 4'hA: t = 7'h77; 4'hB: t = 7'h7C;
      4'hC: t = 7'h39; 4'hD: t = 7'h5E; 4'hE: t = 7'h79; default: t = 7'h71;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] digit_seg(input logic [31:0] disp, input int d,
                                           input logic blank, input logic [7:0] dp);
    logic [3:0] n;
    n = disp[4*d +: 4];
    if (blank && d >= 1 && (disp >> (4*d)) == 32'd0) return 8'hFF;
    return {~dp[d], ~glyph_on(n)};
  endfunction

  function automatic bit is_guard(input int j);
    return (j > 0) && (j % 4 == 0);
  endfunction

  function automatic logic [7:0] model_an(input int j);
    logic [7:0] one;
    one = 8'h01;
    if (is_guard(j)) return 8'hFF;
    return ~(one << ((j / 4) % 8));
  endfunction

  function automatic bit is_frame(input int n);
    return (n > 1) && (n % 32 == 1);
  endfunction

  int          k;
  logic [31:0] m_disp, m_pend;
  logic        m_full;
  logic [7:0]  e_an, e_seg;
  logic        e_ft;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k <= 0; m_disp <= '0; m_pend <= '0; m_full <= 1'b0;
      e_an <= 8'hFF; e_seg <= 8'hFF; e_ft <= 1'b0;
    end else begin
      k    <= k + 1;
      e_an <= model_an(k);
      e_seg <= is_guard(k) ? 8'hFF : digit_seg(m_disp, (k / 4) % 8, blank_lz, dp_mask);
      e_ft <= is_frame(k + 1);
      if (is_frame(k + 1) && m_full) begin
        m_disp <= m_pend;
        m_full <= 1'b0;
      end else if (bus.data_valid && !m_full) begin
        m_pend <= bus.data_in;
        m_full <= 1'b1;
      end
    end
  end

  // ---------------- check helpers ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_ok(input string name, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    end
  endtask

  task automatic wait_frame(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (frame_tick) begin ok = 1'b1; break; end
    end
    bound_ok(name, ok);
  endtask

  task automatic wait_digit(input int d, input string name);
    bit ok;
    logic [7:0] one;
    one = 8'h01;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (AN == ~(one << d)) begin ok = 1'b1; break; end
    end
    bound_ok(name, ok);
  endtask

  task automatic load(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.data_ready) begin ok = 1'b1; break; end
    end
    bound_ok("load_ready", ok);
    bus.data_in    = v;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    $display("load %h accepted, data_ready=%0b", v, bus.data_ready);
  endtask

  typedef struct {
    logic [31:0] value;
    logic        blank;
    logic [7:0]  dp;
    int          digit;
    logic [7:0]  seg;
  } vec_t;

  vec_t vecs [13];
  bit   mon_en = 1'b0;

  initial begin
    vecs[0]  = '{32'h1234ABCD, 1'b0, 8'h00, 0, 8'hA1};
    vecs[1]  = '{32'h1234ABCD, 1'b0, 8'h00, 7, 8'hF9};
    vecs[2]  = '{32'h1234ABCD, 1'b0, 8'h00, 4, 8'h99};
    vecs[3]  = '{32'h00000050, 1'b1, 8'h00, 2, 8'hFF};
    vecs[4]  = '{32'h00000050, 1'b1, 8'h00, 1, 8'h92};
    vecs[5]  = '{32'h00000050, 1'b1, 8'h00, 0, 8'hC0};
    vecs[6]  = '{32'h00000050, 1'b1, 8'hFF, 7, 8'hFF};
    vecs[7]  = '{32'h00000050, 1'b1, 8'hFF, 1, 8'h12};
    vecs[8]  = '{32'h00000000, 1'b1, 8'h00, 0, 8'hC0};
    vecs[9]  = '{32'h00000000, 1'b1, 8'h00, 3, 8'hFF};
    vecs[10] = '{32'h89ABCDEF, 1'b0, 8'h00, 3, 8'hC6};
    vecs[11] = '{32'h89ABCDEF, 1'b0, 8'h01, 0, 8'h0E};
    vecs[12] = '{32'h00000000, 1'b0, 8'h00, 5, 8'hC0};

    bus.data_in    = '0;
    bus.data_valid = 1'b0;

    // Continuous comparison against the model every cycle out of reset.
    fork
      forever begin
        @(negedge clk);
        if (rst && mon_en) begin
          check8("an_model", AN, e_an);
          check8("seg_model", SEG, e_seg);
          check1("frame_tick_model", frame_tick, e_ft);
          check1("ready_model", bus.data_ready, ~m_full);
          total++;
          if (!(AN == 8'hFF || $onehot(~AN))) begin
            bad++;
            $display("FAIL an_onehot: got %h want one-hot or FF", AN);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check8("reset_an", AN, 8'hFF);
    check8("reset_seg", SEG, 8'hFF);
    check1("reset_ready", bus.data_ready, 1'b1);
    check1("reset_ft", frame_tick, 1'b0);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check8("first_an", AN, 8'hFE);
    check8("first_seg", SEG, 8'hC0);
    check1("first_ft", frame_tick, 1'b0);
    for (int d = 1; d < 8; d++) begin
      wait_digit(d, "zero_digit_wait");
      check8("zero_digit_seg", SEG, 8'hC0);
      $display("after reset digit %0d SEG=%h", d, SEG);
    end

    // Table-driven display vectors
    for (int i = 0; i < 13; i++) begin
      blank_lz = vecs[i].blank;
      dp_mask  = vecs[i].dp;
      load(vecs[i].value);
      wait_frame("vec_frame");
      wait_digit(vecs[i].digit, "vec_digit");
      check8("vec_seg", SEG, vecs[i].seg);
      $display("vec %0d value=%h digit=%0d SEG=%h exp=%h", i, vecs[i].value,
               vecs[i].digit, SEG, vecs[i].seg);
    end

    // Back-to-back with data_valid held high
    blank_lz = 1'b0;
    dp_mask  = 8'h00;
    wait_frame("b2b_align");
    repeat (5) @(negedge clk);
    bus.data_in    = 32'h1234ABCD;
    bus.data_valid = 1'b1;
    @(negedge clk);
    check1("b2b_first_taken", bus.data_ready, 1'b0);
    bus.data_in = 32'h0000000E;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (frame_tick) begin ok = 1'b1; break; end
        check1("b2b_refused", bus.data_ready, 1'b0);
      end
      bound_ok("b2b_frame1", ok);
    end
    check1("b2b_ready_back", bus.data_ready, 1'b1);
    @(negedge clk);
    check1("b2b_second_taken", bus.data_ready, 1'b0);
    bus.data_valid = 1'b0;
    wait_digit(0, "b2b_d0_wait");
    check8("b2b_first_shown", SEG, 8'hA1);
    wait_frame("b2b_frame2");
    wait_digit(0, "b2b_d0_wait2");
    check8("b2b_second_shown", SEG, 8'h86);
    $display("back-to-back second value SEG=%h", SEG);

    // Mid-frame reset with pending full
    load(32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check1("mid_pending_full", bus.data_ready, 1'b0);
    #1 rst = 1'b0;
    #1;
    check8("mid_reset_an", AN, 8'hFF);
    check8("mid_reset_seg", SEG, 8'hFF);
    check1("mid_reset_ready", bus.data_ready, 1'b1);
    check1("mid_reset_ft", frame_tick, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check8("mid_rel_an", AN, 8'hFE);
    check8("mid_rel_seg", SEG, 8'hC0);
    wait_frame("mid_frame");
    check1("mid_ready_after", bus.data_ready, 1'b1);
    wait_digit(7, "mid_d7_wait");
    check8("mid_display_zero", SEG, 8'hC0);
    $display("after mid-frame reset digit 7 SEG=%h", SEG);

    // Randomised traffic, checked by the model every cycle
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      bus.data_valid = ($urandom_range(0, 3) == 0);
      bus.data_in    = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 63) == 0) dp_mask = 8'($urandom);
    end
    bus.data_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
